// File: rtl/karthik_halfadder_pkg.sv
// Shared widths, output field offsets and constants for the half-adder bank.
package karthik_halfadder_pkg;
  localparam int N_LANES   = 4;
  localparam int CNT_W     = 8;
  localparam int IO_W      = 8;
  localparam int SUM_LSB   = 0;
  localparam int CARRY_LSB = 4;
  localparam logic [IO_W-1:0] UIO_OE_ALL = 8'hFF;

  // Lane i operands live at ui_in[2i] (a) and ui_in[2i+1] (b).
  function automatic logic [1:0] lane_ops(input logic [IO_W-1:0] ui, input int lane);
    return {ui[2*lane+1], ui[2*lane]};
  endfunction
endpackage

// File: rtl/karthik_halfadder_if.sv
// Bundle of the Tiny Tapeout user-block data pins (everything except clk/rst_n).
interface karthik_halfadder_if;
  import karthik_halfadder_pkg::*;
  logic            ena;
  logic [IO_W-1:0] ui_in;
  logic [IO_W-1:0] uo_out;
  logic [IO_W-1:0] uio_in;
  logic [IO_W-1:0] uio_out;
  logic [IO_W-1:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/karthik_halfadder_cell.sv
// One combinational 1-bit half adder lane.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/karthik_halfadder.sv
// Four half-adder lanes with registered sum/carry outputs and a carry-event counter.
// rst_n is active-high and synchronous; it dominates ena.
module karthik_halfadder
  import karthik_halfadder_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [IO_W-1:0] ui_in,
  output logic [IO_W-1:0] uo_out,
  input  logic [IO_W-1:0] uio_in,
  output logic [IO_W-1:0] uio_out,
  output logic [IO_W-1:0] uio_oe
);
  logic [N_LANES-1:0] sum, carry;
  logic [IO_W-1:0]    uo_d, uo_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               unused_uio;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [1:0] ops;
    assign ops = lane_ops(ui_in, i);
    half_adder_cell u_cell (
      .a     (ops[0]),
      .b     (ops[1]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  always_comb begin
    uo_d  = uo_q;
    cnt_d = cnt_q;
    if (ena) begin
      uo_d[SUM_LSB   +: N_LANES] = sum;
      uo_d[CARRY_LSB +: N_LANES] = carry;
      // Any lane carrying counts as one event; wraps modulo 2^CNT_W.
      if (|carry) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      uo_q  <= '0;
      cnt_q <= '0;
    end else begin
      uo_q  <= uo_d;
      cnt_q <= cnt_d;
    end
  end

  assign uo_out     = uo_q;
  assign uio_out    = cnt_q;
  assign uio_oe     = UIO_OE_ALL;
  assign unused_uio = ^uio_in;
endmodule

// File: tb/tb_karthik_halfadder.sv
// Directed vector bench for karthik_halfadder.
module tb_karthik_halfadder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_run = 0, n_fail = 0;

  karthik_halfadder_if bus();

  karthik_halfadder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .ui_in   (bus.ui_in),
    .uo_out  (bus.uo_out),
    .uio_in  (bus.uio_in),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ena;
    logic [7:0] ui;
    logic [7:0] exp_uo;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample on the falling edge.
  task automatic step(input logic rst, input logic ena, input logic [7:0] ui);
    rst_n      = rst;
    bus.ena    = ena;
    bus.ui_in  = ui;
    bus.uio_in = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'h03, 8'h10, 8'h01};
    vecs[2]  = '{1'b0, 1'b1, 8'h01, 8'h01, 8'h01};
    vecs[3]  = '{1'b0, 1'b1, 8'hFF, 8'hF0, 8'h02};
    vecs[4]  = '{1'b0, 1'b1, 8'h66, 8'h0F, 8'h02};
    vecs[5]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 8'h0C, 8'h20, 8'h01};
    vecs[7]  = '{1'b0, 1'b1, 8'h03, 8'h10, 8'h02};
    vecs[8]  = '{1'b0, 1'b1, 8'h03, 8'h10, 8'h03};
    vecs[9]  = '{1'b0, 1'b0, 8'hFF, 8'h10, 8'h03};
    vecs[10] = '{1'b0, 1'b0, 8'hFF, 8'h10, 8'h03};
    vecs[11] = '{1'b0, 1'b0, 8'hFF, 8'h10, 8'h03};
    vecs[12] = '{1'b0, 1'b0, 8'hFF, 8'h10, 8'h03};
    vecs[13] = '{1'b0, 1'b1, 8'hFF, 8'hF0, 8'h04};
    vecs[14] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00};
    vecs[15] = '{1'b0, 1'b1, 8'hAA, 8'h0F, 8'h00};
    vecs[16] = '{1'b0, 1'b1, 8'h55, 8'h0F, 8'h00};
    vecs[17] = '{1'b0, 1'b1, 8'h09, 8'h03, 8'h00};

    rst_n = 1'b0; bus.ena = 1'b0; bus.ui_in = '0; bus.uio_in = '0;
    @(negedge clk);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].ena, vecs[k].ui);
      chk($sformatf("vec%0d uo_out", k), bus.uo_out, vecs[k].exp_uo);
      chk($sformatf("vec%0d uio_out", k), bus.uio_out, vecs[k].exp_cnt);
      chk($sformatf("vec%0d uio_oe", k), bus.uio_oe, 8'hFF);
    end

    // Hold a lane1 carry for 5 cycles, then idle inputs: count must freeze.
    step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h0C);
    chk("hold0C uio_out", bus.uio_out, 8'h05);
    chk("hold0C uo_out", bus.uo_out, 8'h20);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    chk("idle uio_out", bus.uio_out, 8'h05);
    chk("idle uo_out", bus.uo_out, 8'h00);

    // Counter wrap: 255 carry cycles read FF, the 256th wraps to 00.
    step(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 255; i++) step(1'b0, 1'b1, 8'hC0);
    chk("wrap255 uio_out", bus.uio_out, 8'hFF);
    step(1'b0, 1'b1, 8'hC0);
    chk("wrap256 uio_out", bus.uio_out, 8'h00);
    chk("wrap256 uo_out", bus.uo_out, 8'h80);
    step(1'b0, 1'b1, 8'hC0);
    chk("wrap257 uio_out", bus.uio_out, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
